// File: rtl/apb_master_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// apb_master_ctrl : one command -> one APB transfer (SETUP, ACCESS+waits).
// Optional macro TIMEOUT_EN aborts ACCESS after TIMEOUT_CYC stalled cycles.
// Revision 1.0
// ---------------------------------------------------------------------------
module apb_master_ctrl #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              pclk,
  input  logic              preset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [7:0]          wait_q, wait_d, wait_inc;
  logic                psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d, rsp_rdata_q, rsp_rdata_d;
  logic                rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic                rsp_timeout_q, rsp_timeout_d, cmd_ready_q, cmd_ready_d;

`ifdef TIMEOUT_EN
  localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT_CYC);
`else
  logic [7:0] unused_timeout_cyc;
  assign unused_timeout_cyc = 8'(TIMEOUT_CYC);
`endif

  assign wait_inc = (wait_q == 8'hFF) ? 8'hFF : wait_q + 8'd1;

  always_comb begin
    state_d       = state_q;
    wait_d        = wait_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    cmd_ready_d   = cmd_ready_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          pwrite_d    = cmd_write;
          paddr_d     = cmd_addr;
          pwdata_d    = cmd_write ? cmd_wdata : '0;
          psel_d      = 1'b1;
          penable_d   = 1'b0;
          cmd_ready_d = 1'b0;
          state_d     = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
      end
      ACCESS: begin
        if (pready) begin
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = pwrite_q ? '0 : prdata;
          rsp_err_d     = pslverr;
          rsp_timeout_d = 1'b0;
          wait_d        = 8'd0;
          cmd_ready_d   = 1'b1;
          state_d       = IDLE;
        end else begin
          wait_d = wait_inc;
`ifdef TIMEOUT_EN
          // Abort on the TIMEOUT_CYC-th stalled ACCESS cycle; pready above wins.
          if (wait_inc == TO_LIMIT) begin
            psel_d        = 1'b0;
            penable_d     = 1'b0;
            rsp_valid_d   = 1'b1;
            rsp_rdata_d   = '0;
            rsp_err_d     = 1'b1;
            rsp_timeout_d = 1'b1;
            wait_d        = 8'd0;
            cmd_ready_d   = 1'b1;
            state_d       = IDLE;
          end
`endif
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge pclk) begin
    if (!preset_n) begin
      state_q       <= IDLE;
      wait_q        <= 8'd0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
      cmd_ready_q   <= 1'b1;
    end else begin
      state_q       <= state_d;
      wait_q        <= wait_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
      cmd_ready_q   <= cmd_ready_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
`ifdef TIMEOUT_EN
  assign rsp_timeout = rsp_timeout_q;
`else
  assign rsp_timeout = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_apb_master_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_apb_master_ctrl : randomized bench with a transaction-level timing model.
// Revision 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_apb_master_ctrl;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam int TO = 16;

  logic          pclk = 1'b0;
  logic          preset_n = 1'b0;
  logic          cmd_valid = 1'b0, cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0, prdata = '0;
  logic          pready = 1'b0, pslverr = 1'b0;
  logic          cmd_ready, rsp_valid, rsp_err, rsp_timeout;
  logic          psel, penable, pwrite;
  logic [DW-1:0] rsp_rdata, pwdata;
  logic [AW-1:0] paddr;

  int checks = 0;
  int failures = 0;

  // Values the model says the DUT must be holding while idle.
  logic          exp_write = 1'b0, exp_err = 1'b0, exp_to = 1'b0;
  logic [AW-1:0] exp_addr = '0;
  logic [DW-1:0] exp_wdata = '0, exp_rdata = '0;

  always #5 pclk = ~pclk;

  apb_master_ctrl #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
    .pclk(pclk), .preset_n(preset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .rsp_timeout(rsp_timeout),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic model_reset();
    exp_write = 1'b0; exp_addr = '0; exp_wdata = '0;
    exp_rdata = '0; exp_err = 1'b0; exp_to = 1'b0;
  endtask

  // One transfer with w wait states, starting in the current cycle N.
  task automatic run_xfer(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                          input int w, input logic [DW-1:0] rd, input bit err, input bit hold);
    logic [3:0]    exp_ctl;
    logic [DW-1:0] wd_eff;
    wd_eff = wr ? wd : {DW{1'b0}};
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL xfer_ready_at_issue got=%b exp=1", cmd_ready);
    end
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = wd;
    for (int k = 1; k <= 3 + w; k++) begin
      step();
      if (!hold) cmd_valid = 1'b0;
      if (k == 2 + w) begin
        pready = 1'b1; prdata = rd; pslverr = err;
      end else begin
        pready = 1'b0; prdata = DW'($urandom); pslverr = 1'($urandom);
      end
      exp_ctl = {(k <= 2 + w), (k >= 2 && k <= 2 + w), (k == 3 + w), (k == 3 + w)};
      checks++;
      if ({psel, penable, cmd_ready, rsp_valid} !== exp_ctl) begin
        failures++;
        $display("FAIL xfer_ctl k=%0d w=%0d psel/pen/rdy/vld got=%b exp=%b",
                 k, w, {psel, penable, cmd_ready, rsp_valid}, exp_ctl);
      end
      if (k <= 2 + w) begin
        checks++;
        if ({pwrite, paddr, pwdata} !== {wr, a, wd_eff}) begin
          failures++;
          $display("FAIL xfer_apb k=%0d got=%b/%h/%h exp=%b/%h/%h",
                   k, pwrite, paddr, pwdata, wr, a, wd_eff);
        end
      end
    end
    exp_write = wr; exp_addr = a; exp_wdata = wd_eff;
    exp_rdata = wr ? {DW{1'b0}} : rd; exp_err = err; exp_to = 1'b0;
    checks++;
    if ({rsp_rdata, rsp_err, rsp_timeout} !== {exp_rdata, exp_err, exp_to}) begin
      failures++;
      $display("FAIL xfer_rsp got=%h/%b/%b exp=%h/%b/%b",
               rsp_rdata, rsp_err, rsp_timeout, exp_rdata, exp_err, exp_to);
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      cmd_valid = 1'b0; pready = 1'($urandom); prdata = DW'($urandom); pslverr = 1'($urandom);
      checks++;
      if ({psel, penable, cmd_ready, rsp_valid} !== 4'b0010) begin
        failures++;
        $display("FAIL idle_ctl got=%b exp=0010", {psel, penable, cmd_ready, rsp_valid});
      end
      checks++;
      if ({rsp_rdata, rsp_err, rsp_timeout, pwrite, paddr, pwdata} !==
          {exp_rdata, exp_err, exp_to, exp_write, exp_addr, exp_wdata}) begin
        failures++;
        $display("FAIL idle_hold got=%h/%b/%b/%b/%h/%h exp=%h/%b/%b/%b/%h/%h",
                 rsp_rdata, rsp_err, rsp_timeout, pwrite, paddr, pwdata,
                 exp_rdata, exp_err, exp_to, exp_write, exp_addr, exp_wdata);
      end
    end
    pready = 1'b0;
  endtask

  task automatic test_reset();
    preset_n = 1'b0;
    step(); step();
    preset_n = 1'b1;
    model_reset();
    checks++;
    if ({psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, cmd_ready}
        !== {1'b0, 1'b0, 1'b0, {AW{1'b0}}, {DW{1'b0}}, 1'b0, {DW{1'b0}}, 1'b0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL reset_values psel=%b pen=%b pwr=%b addr=%h wd=%h vld=%b rd=%h err=%b to=%b rdy=%b",
               psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, cmd_ready);
    end
    idle_cycles(2);
  endtask

  task automatic test_write();
    run_xfer(1'b1, 8'h01, 8'h10, 0, 8'hA5, 1'b0, 1'b0);
    idle_cycles(2);
  endtask

  task automatic test_read_wait();
    run_xfer(1'b0, 8'h01, 8'hFF, 2, 8'h13, 1'b0, 1'b0);
    idle_cycles(1);
  endtask

  task automatic test_slverr();
    run_xfer(1'b1, 8'h07, 8'h3C, 1, 8'h00, 1'b1, 1'b0);
    idle_cycles(1);
    run_xfer(1'b0, 8'h01, 8'h00, 0, 8'h5C, 1'b0, 1'b0);
    idle_cycles(1);
  endtask

  task automatic test_back_to_back();
    run_xfer(1'b1, 8'h01, 8'h11, 0, 8'h00, 1'b0, 1'b1);
    run_xfer(1'b0, 8'h01, 8'h00, 0, 8'h11, 1'b0, 1'b0);
    idle_cycles(3);
  endtask

  task automatic test_random();
    bit hold;
    for (int i = 0; i < 24; i++) begin
      hold = (i != 23) && 1'($urandom);
      run_xfer(1'($urandom), AW'($urandom), DW'($urandom), $urandom_range(0, 15),
               DW'($urandom), 1'($urandom), hold);
      if (!hold) idle_cycles($urandom_range(0, 2));
    end
    idle_cycles(1);
  endtask

  task automatic test_reset_mid();
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h42; cmd_wdata = 8'h99;
    pready = 1'b0;
    step();                 // SETUP
    cmd_valid = 1'b0;
    step();                 // ACCESS, stalled
    step();                 // ACCESS, stalled; reset sampled at the next edge
    preset_n = 1'b0;
    step();
    preset_n = 1'b1;
    model_reset();
    checks++;
    if ({psel, penable, cmd_ready, rsp_valid, paddr} !== {4'b0010, {AW{1'b0}}}) begin
      failures++;
      $display("FAIL reset_mid got=%b/%h exp=0010/00", {psel, penable, cmd_ready, rsp_valid}, paddr);
    end
    idle_cycles(3);
  endtask

  task automatic test_timeout();
`ifdef TIMEOUT_EN
    logic [3:0] exp_ctl;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h22; cmd_wdata = 8'h00;
    for (int k = 1; k <= TO + 2; k++) begin
      step();
      cmd_valid = 1'b0; pready = 1'b0; prdata = DW'($urandom); pslverr = 1'b0;
      exp_ctl = {(k <= TO + 1), (k >= 2 && k <= TO + 1), (k == TO + 2), (k == TO + 2)};
      checks++;
      if ({psel, penable, cmd_ready, rsp_valid} !== exp_ctl) begin
        failures++;
        $display("FAIL timeout_ctl k=%0d got=%b exp=%b", k, {psel, penable, cmd_ready, rsp_valid}, exp_ctl);
      end
    end
    exp_write = 1'b0; exp_addr = 8'h22; exp_wdata = '0;
    exp_rdata = '0; exp_err = 1'b1; exp_to = 1'b1;
    checks++;
    if ({rsp_rdata, rsp_err, rsp_timeout} !== {exp_rdata, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL timeout_rsp got=%h/%b/%b exp=00/1/1", rsp_rdata, rsp_err, rsp_timeout);
    end
    idle_cycles(2);
    // Ready on the final allowed cycle completes normally.
    run_xfer(1'b0, 8'h05, 8'h00, TO - 1, 8'h6B, 1'b0, 1'b0);
    idle_cycles(2);
`else
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h22; cmd_wdata = 8'h77;
    step();
    cmd_valid = 1'b0; pready = 1'b0;
    for (int k = 0; k < 100; k++) begin
      step();
      checks++;
      if ({psel, penable, cmd_ready, rsp_valid} !== 4'b1100) begin
        failures++;
        $display("FAIL no_timeout_hold k=%0d got=%b exp=1100", k, {psel, penable, cmd_ready, rsp_valid});
      end
    end
    preset_n = 1'b0;
    step();
    preset_n = 1'b1;
    model_reset();
    idle_cycles(2);
`endif
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_wait();
    test_slverr();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
